// File: rtl/mont_result_serializer.sv
// Montgomery result serializer: captures a finished modular product in one cycle
// and streams it onto a word-wide valid/ready bus, least-significant word first.
`timescale 1ns/1ps
module mont_result_serializer #(
  parameter  int size_input = 1024,
  parameter  int word_size  = 64,
  localparam int iteration  = size_input / word_size,
  localparam int idx_w      = $clog2(iteration)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [size_input-1:0] result_in,
  output logic [word_size-1:0]  bus_out,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_last,
  output logic [idx_w-1:0]      word_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [idx_w-1:0] last_idx = idx_w'(iteration - 1);
  localparam logic [idx_w-1:0] one_idx  = idx_w'(1);

  state_t                state_q, state_d;
  logic [size_input-1:0] shreg_q, shreg_d;
  logic [idx_w-1:0]      cnt_q, cnt_d;
  logic [word_size-1:0]  bus_out_q, bus_out_d;
  logic                  bus_valid_q, bus_valid_d;
  logic                  bus_last_q, bus_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= {size_input{1'b0}};
      cnt_q       <= {idx_w{1'b0}};
      bus_out_q   <= {word_size{1'b0}};
      bus_valid_q <= 1'b0;
      bus_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_last_q  <= bus_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    bus_last_d  = bus_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // A load while a result is still owned is dropped and flagged until reset.
    overrun_d   = overrun_q | (load & busy_q);

    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d     = result_in;
          cnt_d       = {idx_w{1'b0}};
          bus_out_d   = result_in[word_size-1:0];
          bus_valid_d = 1'b1;
          bus_last_d  = (last_idx == {idx_w{1'b0}});
          busy_d      = 1'b1;
          state_d     = SEND;
        end else begin
          bus_out_d   = {word_size{1'b0}};
          bus_valid_d = 1'b0;
          bus_last_d  = 1'b0;
          busy_d      = 1'b0;
        end
      end
      SEND: begin
        if (bus_valid_q && bus_ready) begin
          if (cnt_q == last_idx) begin
            bus_out_d   = {word_size{1'b0}};
            bus_valid_d = 1'b0;
            bus_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            cnt_d       = {idx_w{1'b0}};
            state_d     = IDLE;
          end else begin
            shreg_d    = shreg_q >> word_size;
            bus_out_d  = shreg_q[2*word_size-1:word_size];
            cnt_d      = cnt_q + one_idx;
            bus_last_d = ((cnt_q + one_idx) == last_idx);
          end
        end else begin
          bus_valid_d = bus_valid_q;
        end
      end
      default: begin
        state_d     = IDLE;
        bus_out_d   = {word_size{1'b0}};
        bus_valid_d = 1'b0;
        bus_last_d  = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = {idx_w{1'b0}};
      end
    endcase
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign bus_last  = bus_last_q;
  assign word_idx  = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mont_result_serializer.sv
// Directed bench for mont_result_serializer: streaming, backpressure, overrun,
// back-to-back loads, mid-stream reset and full-width reassembly.
`timescale 1ns/1ps
module tb_mont_result_serializer;

  localparam int SZ = 1024;
  localparam int WS = 64;
  localparam int NW = SZ / WS;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [SZ-1:0] result_in;
  logic [WS-1:0] bus_out;
  logic          bus_valid;
  logic          bus_ready;
  logic          bus_last;
  logic [3:0]    word_idx;
  logic          busy;
  logic          done;
  logic          overrun;

  int vectors = 0;
  int miscompares = 0;

  mont_result_serializer #(.size_input(SZ), .word_size(WS)) dut (
    .clk(clk), .reset(reset), .load(load), .result_in(result_in),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_last(bus_last), .word_idx(word_idx), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [SZ-1:0] mk(input logic [WS-1:0] base);
    logic [SZ-1:0] r;
    for (int w = 0; w < NW; w++) r[w*WS +: WS] = base + WS'(w);
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; load = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Load a stream with base pattern and ready high; leaves first word visible.
  task automatic start(input logic [SZ-1:0] data);
    load = 1'b1; result_in = data;
    step();
    load = 1'b0;
  endtask

  logic [SZ-1:0] modm1;
  logic [SZ-1:0] reasm;
  int            xfers;
  int            cyc;
  logic [3:0]    pat;

  initial begin
    reset = 1'b1; load = 1'b0; bus_ready = 1'b1; result_in = {SZ{1'b0}};
    step();
    step();
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_idx", 64'(word_idx), 64'd0);
    chk("rst_out", bus_out, 64'd0);
    chk("rst_last", 64'(bus_last), 64'd0);
    reset = 1'b0;

    // Stream 1: ready tied high, 16 consecutive words then done pulse.
    start(mk(64'd1));
    chk("s1_busy", 64'(busy), 64'd1);
    for (int w = 0; w < NW; w++) begin
      chk("s1_word", bus_out, 64'(w + 1));
      chk("s1_idx", 64'(word_idx), 64'(w));
      chk("s1_valid", 64'(bus_valid), 64'd1);
      chk("s1_last", 64'(bus_last), (w == NW - 1) ? 64'd1 : 64'd0);
      chk("s1_done_early", 64'(done), 64'd0);
      step();
    end
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_busy_low", 64'(busy), 64'd0);
    chk("s1_valid_low", 64'(bus_valid), 64'd0);
    chk("s1_out_zero", bus_out, 64'd0);
    step();
    chk("s1_done_pulse", 64'(done), 64'd0);

    // Stream 2: backpressure pattern 1,0,0,1 repeating.
    pat = 4'b1001;
    start(mk(64'd1));
    xfers = 0;
    cyc = 0;
    while (xfers < NW && cyc < 200) begin
      bus_ready = pat[cyc % 4];
      chk("s2_word", bus_out, 64'(xfers + 1));
      chk("s2_idx", 64'(word_idx), 64'(xfers));
      chk("s2_valid", 64'(bus_valid), 64'd1);
      step();
      if (bus_ready) xfers++;
      chk("s2_done", 64'(done), (xfers == NW && bus_ready) ? 64'd1 : 64'd0);
      cyc++;
    end
    chk("s2_xfers", 64'(xfers), 64'(NW));
    bus_ready = 1'b1;
    step();

    // Stream 3: second load at transfer 5 is ignored and flags overrun.
    start(mk(64'd1));
    for (int i = 1; i < NW; i++) begin
      if (i == 5) begin
        load = 1'b1; result_in = mk(64'h100);
      end
      step();
      load = 1'b0;
      chk("s3_word", bus_out, 64'(i + 1));
      chk("s3_ovr", 64'(overrun), (i >= 5) ? 64'd1 : 64'd0);
    end
    step();
    chk("s3_done", 64'(done), 64'd1);
    step();
    step();
    chk("s3_ovr_sticky", 64'(overrun), 64'd1);

    // Stream 4: back-to-back load accepted in the done cycle.
    do_reset();
    chk("s4_ovr_clr", 64'(overrun), 64'd0);
    start(mk(64'd1));
    for (int i = 1; i < NW; i++) step();
    chk("s4_last1", bus_out, 64'd16);
    step();
    chk("s4_done1", 64'(done), 64'd1);
    load = 1'b1; result_in = mk(64'hA0);
    step();
    load = 1'b0;
    for (int w = 0; w < NW; w++) begin
      chk("s4_word", bus_out, 64'hA0 + 64'(w));
      chk("s4_idx", 64'(word_idx), 64'(w));
      chk("s4_ovr", 64'(overrun), 64'd0);
      step();
    end
    chk("s4_done2", 64'(done), 64'd1);
    step();

    // Stream 5: reset at transfer 8 discards the rest.
    start(mk(64'd1));
    for (int i = 1; i < 8; i++) step();
    chk("s5_pre_idx", 64'(word_idx), 64'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5_valid", 64'(bus_valid), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_idx", 64'(word_idx), 64'd0);
    chk("s5_done", 64'(done), 64'd0);
    chk("s5_out", bus_out, 64'd0);
    step();
    chk("s5_done_after", 64'(done), 64'd0);

    // Stream 6: modulus-1 pattern reassembled bit-exactly.
    for (int w = 0; w < NW; w++)
      modm1[w*WS +: WS] = (w == NW - 1) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
    start(modm1);
    reasm = {SZ{1'b0}};
    cyc = 0;
    xfers = 0;
    while (xfers < NW && cyc < 100) begin
      if (bus_valid) begin
        reasm[xfers*WS +: WS] = bus_out;
        chk("s6_idx", 64'(word_idx), 64'(xfers));
        xfers++;
      end
      step();
      cyc++;
    end
    chk("s6_xfers", 64'(xfers), 64'(NW));
    chk("s6_done", 64'(done), 64'd1);
    vectors++;
    assert (reasm === modm1) else begin
      miscompares++;
      $error("FAIL s6_reasm: observed %h expected %h", reasm[WS*2-1:0], modm1[WS*2-1:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
